pnr_polarity_ctrl: RTL and testbench
====================================

PNR_POLARITY_CTRL -- requirements
Module: pnr_polarity_ctrl

Interface
REQ-001 Parameter WIN_LOG2, default 10, SHALL set the calibration window to N = 2^WIN_LOG2 samples (legal range 2..16).
REQ-002 Parameter THRESH, default 15'd512, SHALL set the minimum excursion magnitude for a valid polarity decision.
REQ-003 clk_i  in  1  ADC sample clock; the single clock, all logic on its rising edge.
REQ-004 rstn_i  in  1  reset, synchronous, active-low.
REQ-005 adc_i  in  14  raw ADC sample, signed two's complement.
REQ-006 mode_i  in  2  00 manual non-invert; 01 manual invert; 10 auto; 11 hold.
REQ-007 cal_start_i  in  1  single-cycle request to start auto calibration.
REQ-008 frame_idle_i  in  1  high when downstream PNR counting is not acquiring, so polarity may change.
REQ-009 is_inverse_o  out  1  applied polarity select for the inversion datapath.
REQ-010 cal_busy_o  out  1  high while a calibration is in progress.
REQ-011 cal_done_o  out  1  one-cycle pulse when a calibration finishes, whether it passes or fails.
REQ-012 cal_fail_o  out  1  sticky: last calibration found no excursion of at least THRESH.
REQ-013 pending_o  out  1  requested polarity differs from applied polarity and awaits frame_idle_i.
REQ-014 max_o / min_o  out  14 each  signed extremes of the last completed window.

Function
REQ-015 The FSM SHALL have the states IDLE, MEASURE, DECIDE and COMMIT; all outputs SHALL be registered.
REQ-016 IDLE -> MEASURE SHALL occur on an edge where cal_start_i=1 and mode_i=10; cal_start_i SHALL be ignored in any other state or mode.
REQ-017 The same edge SHALL clear cal_fail_o, set cal_busy_o, and clear the sample counter, running max, running min and accumulator.
REQ-018 MEASURE SHALL capture adc_i on each of edges 1..N after the start edge, updating max, min and a signed sum of 14+WIN_LOG2 bits, and SHALL go to DECIDE on edge N.
REQ-019 DECIDE, on edge N+1, SHALL:
- compute mean = sum >>> WIN_LOG2 (arithmetic, floor);
- compute pos = max - mean and neg = mean - min, each 15-bit unsigned;
- latch max_o and min_o.
REQ-020 In DECIDE, if both pos < THRESH and neg < THRESH, the block SHALL set cal_fail_o, pulse cal_done_o, drop cal_busy_o, leave is_inverse_o unchanged and return to IDLE.
REQ-021 Otherwise the block SHALL set the requested polarity to 1 if neg > pos, else 0 (ties give 0), and go to COMMIT.
REQ-022 In COMMIT, on the first edge with frame_idle_i=1, the block SHALL in that same edge:
- load is_inverse_o with the requested polarity;
- pulse cal_done_o;
- drop cal_busy_o;
- go to IDLE.
While frame_idle_i=0 it SHALL wait indefinitely.
REQ-023 Best-case latency SHALL therefore be is_inverse_o valid after edge N+2 from the start edge.
REQ-024 In IDLE with mode_i[1]=0, if mode_i[0] != is_inverse_o and frame_idle_i=1, is_inverse_o SHALL take mode_i[0] on that edge; with frame_idle_i=0 the change SHALL be held off.
REQ-025 pending_o SHALL equal (state=COMMIT and requested != is_inverse_o) or (state=IDLE, mode_i[1]=0 and mode_i[0] != is_inverse_o), registered.
REQ-026 If mode_i leaves 10 while in MEASURE, DECIDE or COMMIT, the block SHALL abort to IDLE on the next edge:
- cal_busy_o drops;
- no cal_done_o pulse;
- cal_fail_o, max_o, min_o and is_inverse_o are unchanged.
REQ-027 Mode 11, and mode 10 with no calibration running, SHALL hold is_inverse_o indefinitely.

Reset
REQ-028 With rstn_i=0 at an edge, the block SHALL reset all of the following, with reset taking priority over every other event:
- FSM to IDLE;
- is_inverse_o, cal_busy_o, cal_done_o, cal_fail_o and pending_o to 0;
- max_o, min_o, counter and accumulator to 0.
REQ-029 Reset during MEASURE or COMMIT SHALL discard the calibration without a cal_done_o pulse.

Verification (WIN_LOG2=4, N=16, THRESH=100 unless stated)
REQ-030 Reset: rstn_i low for 2 edges with mode_i=01 -> all outputs 0. After release with frame_idle_i=1 -> is_inverse_o=1 after the first edge.
REQ-031 Negative pulse: mode 10, start, then one sample of -500 and fifteen of 0, frame_idle_i=1. Expected: mean=-32, neg=468, pos=32, min_o=-500, max_o=0, is_inverse_o=1, cal_done_o pulse at edge 18.
REQ-032 Flat input: all samples 20. Expected: pos=neg=0, cal_fail_o=1, cal_done_o pulse at edge 17, is_inverse_o unchanged.
REQ-033 Gating: positive pulse while is_inverse_o=1, with frame_idle_i=0 for 10 cycles in COMMIT. Expected: pending_o=1 and cal_busy_o=1 held; is_inverse_o goes to 0 on the first edge with frame_idle_i high.
REQ-034 Abort: mode_i forced to 00 at edge 8 of MEASURE. Expected: cal_busy_o drops next edge with no cal_done_o; then is_inverse_o goes to 0 through the manual path.
REQ-035 Second start and tie: cal_start_i pulsed mid-MEASURE is ignored and the window length stays 16. Samples {+300, -300, 0 x14} give mean=0 and pos=neg=300, so is_inverse_o=0.

Source files
------------

// File: rtl/pnr_polarity_ctrl.sv
// pnr_polarity_ctrl: picks the ADC inversion polarity, manually or by measuring signal excursions over a window
module pnr_polarity_ctrl #(
  parameter int          WIN_LOG2 = 10,
  parameter logic [14:0] THRESH   = 15'd512
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [13:0] adc_i,
  input  logic [1:0]  mode_i,
  input  logic        cal_start_i,
  input  logic        frame_idle_i,
  output logic        is_inverse_o,
  output logic        cal_busy_o,
  output logic        cal_done_o,
  output logic        cal_fail_o,
  output logic        pending_o,
  output logic [13:0] max_o,
  output logic [13:0] min_o
);
  localparam int SW = 14 + WIN_LOG2;
  typedef enum logic [1:0] {IDLE, MEASURE, DECIDE, COMMIT} state_t;
  state_t state;
  logic [WIN_LOG2-1:0] cnt;
  logic signed [SW-1:0] sum;
  logic signed [13:0] run_max, run_min, sample, mean;
  logic [14:0] pos, neg;
  logic req, auto, mism, fail_now, req_now;
  assign sample = $signed(adc_i);
  assign mean = 14'(sum >>> WIN_LOG2);
  // excursions are never negative, so 15 bits hold the full 14-bit signed span
  assign pos = {run_max[13], run_max} - {mean[13], mean};
  assign neg = {mean[13], mean} - {run_min[13], run_min};
  assign auto = mode_i == 2'b10;
  assign mism = !mode_i[1] && mode_i[0] != is_inverse_o;
  assign fail_now = pos < THRESH && neg < THRESH;
  assign req_now = neg > pos;
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      is_inverse_o <= 1'b0;
      cal_busy_o <= 1'b0;
      cal_done_o <= 1'b0;
      cal_fail_o <= 1'b0;
      pending_o <= 1'b0;
      max_o <= '0;
      min_o <= '0;
      cnt <= '0;
      sum <= '0;
      run_max <= '0;
      run_min <= '0;
      req <= 1'b0;
    end else begin
      cal_done_o <= 1'b0;
      if (state != IDLE && !auto) begin
        state <= IDLE;
        cal_busy_o <= 1'b0;
        pending_o <= mism;
      end else begin
        case (state)
          IDLE: begin
            if (auto && cal_start_i) begin
              state <= MEASURE;
              cal_busy_o <= 1'b1;
              cal_fail_o <= 1'b0;
              pending_o <= 1'b0;
              cnt <= '0;
              sum <= '0;
              run_max <= '0;
              run_min <= '0;
            end else begin
              if (mism && frame_idle_i) is_inverse_o <= mode_i[0];
              pending_o <= mism && !frame_idle_i;
            end
          end
          MEASURE: begin
            cnt <= cnt + 1'b1;
            sum <= sum + SW'(sample);
            // first sample seeds both extremes so a flat window reads zero excursion
            run_max <= (cnt == '0 || sample > run_max) ? sample : run_max;
            run_min <= (cnt == '0 || sample < run_min) ? sample : run_min;
            if (&cnt) state <= DECIDE;
          end
          DECIDE: begin
            max_o <= run_max;
            min_o <= run_min;
            if (fail_now) begin
              state <= IDLE;
              cal_fail_o <= 1'b1;
              cal_done_o <= 1'b1;
              cal_busy_o <= 1'b0;
            end else begin
              state <= COMMIT;
              req <= req_now;
              pending_o <= req_now != is_inverse_o;
            end
          end
          COMMIT: begin
            if (frame_idle_i) begin
              state <= IDLE;
              is_inverse_o <= req;
              cal_done_o <= 1'b1;
              cal_busy_o <= 1'b0;
              pending_o <= 1'b0;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pnr_polarity_ctrl.sv
// tb_pnr_polarity_ctrl: directed vectors with hand-computed expectations, WIN_LOG2=4, THRESH=100
module tb_pnr_polarity_ctrl;
  logic clk = 1'b0;
  logic rstn, cal_start, frame_idle;
  logic [13:0] adc;
  logic [1:0] mode;
  logic is_inv, busy, done, fail, pending;
  logic [13:0] max_v, min_v;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  pnr_polarity_ctrl #(.WIN_LOG2(4), .THRESH(15'd100)) dut (
    .clk_i(clk), .rstn_i(rstn), .adc_i(adc), .mode_i(mode), .cal_start_i(cal_start),
    .frame_idle_i(frame_idle), .is_inverse_o(is_inv), .cal_busy_o(busy), .cal_done_o(done),
    .cal_fail_o(fail), .pending_o(pending), .max_o(max_v), .min_o(min_v)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic start_cal;
    mode = 2'b10;
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
  endtask
  task automatic window(input int first, input int second, input int rest, input int restart_idx);
    for (int i = 0; i < 16; i++) begin
      adc = 14'(i == 0 ? first : i == 1 ? second : rest);
      cal_start = i == restart_idx;
      tick();
    end
    cal_start = 1'b0;
  endtask
  initial begin
    rstn = 1'b0; mode = 2'b01; frame_idle = 1'b1; cal_start = 1'b0; adc = '0;
    tick(); tick();
    check("rst_inv", is_inv, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fail", fail, 0);
    check("rst_pend", pending, 0);
    check("rst_max", $signed(max_v), 0);
    check("rst_min", $signed(min_v), 0);
    rstn = 1'b1;
    tick();
    check("rel_inv", is_inv, 1);
    mode = 2'b00;
    tick();
    check("man0_inv", is_inv, 0);
    // negative pulse: mean -32, neg 468, pos 32
    start_cal();
    check("neg_busy0", busy, 1);
    window(-500, 0, 0, -1);
    check("neg_busy16", busy, 1);
    check("neg_done16", done, 0);
    tick();
    check("neg_busy17", busy, 1);
    check("neg_done17", done, 0);
    check("neg_pend17", pending, 1);
    check("neg_max", $signed(max_v), 0);
    check("neg_min", $signed(min_v), -500);
    tick();
    check("neg_done18", done, 1);
    check("neg_inv18", is_inv, 1);
    check("neg_busy18", busy, 0);
    check("neg_pend18", pending, 0);
    tick();
    check("neg_done19", done, 0);
    // flat window fails on edge 17
    start_cal();
    window(20, 20, 20, -1);
    check("flat_done16", done, 0);
    tick();
    check("flat_done17", done, 1);
    check("flat_fail17", fail, 1);
    check("flat_busy17", busy, 0);
    check("flat_inv17", is_inv, 1);
    check("flat_max", $signed(max_v), 20);
    check("flat_min", $signed(min_v), 20);
    tick();
    check("flat_done18", done, 0);
    check("flat_fail18", fail, 1);
    // gating: positive pulse held in COMMIT by frame_idle low
    start_cal();
    check("gate_failclr", fail, 0);
    check("gate_busy0", busy, 1);
    window(500, 0, 0, -1);
    frame_idle = 1'b0;
    tick();
    check("gate_pend17", pending, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("gate_pend", pending, 1);
      check("gate_busy", busy, 1);
      check("gate_inv", is_inv, 1);
      check("gate_done", done, 0);
    end
    frame_idle = 1'b1;
    tick();
    check("gate_inv_rel", is_inv, 0);
    check("gate_done_rel", done, 1);
    check("gate_busy_rel", busy, 0);
    check("gate_pend_rel", pending, 0);
    mode = 2'b11;
    tick(); tick();
    check("hold_inv", is_inv, 0);
    mode = 2'b01;
    tick();
    check("man1_inv", is_inv, 1);
    // abort mid-measure via manual mode 00
    start_cal();
    for (int i = 0; i < 8; i++) begin
      adc = 14'(400);
      tick();
    end
    check("abort_busy8", busy, 1);
    mode = 2'b00;
    tick();
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_inv", is_inv, 1);
    check("abort_fail", fail, 0);
    check("abort_max", $signed(max_v), 500);
    check("abort_min", $signed(min_v), 0);
    tick();
    check("abort_inv_man", is_inv, 0);
    check("abort_done2", done, 0);
    mode = 2'b01;
    tick();
    check("tie_pre_inv", is_inv, 1);
    // tie with a second start ignored mid-window
    start_cal();
    window(300, -300, 0, 5);
    check("tie_busy16", busy, 1);
    check("tie_done16", done, 0);
    tick();
    check("tie_done17", done, 0);
    check("tie_max", $signed(max_v), 300);
    check("tie_min", $signed(min_v), -300);
    check("tie_pend17", pending, 1);
    tick();
    check("tie_done18", done, 1);
    check("tie_inv18", is_inv, 0);
    mode = 2'b01;
    tick();
    check("rc_pre_inv", is_inv, 1);
    // reset while waiting in COMMIT discards the calibration
    start_cal();
    window(-500, 0, 0, -1);
    frame_idle = 1'b0;
    tick();
    check("rc_busy17", busy, 1);
    rstn = 1'b0;
    tick();
    check("rc_busy", busy, 0);
    check("rc_done", done, 0);
    check("rc_inv", is_inv, 0);
    check("rc_pend", pending, 0);
    check("rc_min", $signed(min_v), 0);
    rstn = 1'b1;
    frame_idle = 1'b1;
    tick();
    check("rc_done_after", done, 0);
    check("rc_busy_after", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
